baugh_mac_accumulator: RTL



---
 rtl/baugh_mac_accumulator.sv | 134 +++++++++++++
 1 files changed

// File: rtl/baugh_mac_accumulator.sv
// baugh_mac_accumulator: signed 4x4 Baugh-Wooley multiply-accumulate stage.
// Sums every LEN products into an ACC_W-bit two's-complement dot product.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   in_valid/in_ready/in_a/in_b  operand pair stream (signed 4-bit)
//   out_valid/out_ready          result handshake
//   out_acc                      signed dot product (ACC_W bits)
//   out_ovf                      sticky signed-overflow flag for this result

// Baugh_Multiplier: 4x4 signed multiplier, 8-bit two's-complement product.
// Ports: a, b (signed 4-bit operands), p (signed 8-bit product).
module Baugh_Multiplier (
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic [7:0] p
);

   // Plain partial products for the magnitude bits, a3*b3 at weight 2^6,
   // complemented sign-row terms, plus the constant 2^4 + 2^7 (mod 2^8).
   always_comb begin
      p = 8'h90;
      for (int i = 0; i < 3; i++) begin
         for (int j = 0; j < 3; j++) begin
            p = p + ((a[i] & b[j]) ? (8'd1 << (i + j)) : 8'd0);
         end
      end
      p = p + ((a[3] & b[3]) ? 8'h40 : 8'h00);
      for (int j = 0; j < 3; j++) begin
         p = p + ((a[3] & b[j]) ? 8'd0 : (8'd1 << (3 + j)));
         p = p + ((a[j] & b[3]) ? 8'd0 : (8'd1 << (3 + j)));
      end
   end

endmodule

module baugh_mac_accumulator #(
   parameter int LEN   = 4,
   parameter int ACC_W = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_a,
   input  logic [3:0]       in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_acc,
   output logic             out_ovf
);

   localparam int CW = (LEN > 1) ? $clog2(LEN) : 1;

   logic [3:0]       op_a;
   logic [3:0]       op_b;
   logic             p_valid;
   logic [7:0]       prod;
   logic [ACC_W-1:0] prod_ext;
   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] sum;
   logic             ovf_add;
   logic             grp_ovf;
   logic [CW-1:0]    cnt;
   logic             last;
   logic             stall;
   logic             absorb;
   logic             load;

   Baugh_Multiplier u_mul (
      .a (op_a),
      .b (op_b),
      .p (prod)
   );

   always_comb begin
      prod_ext = ACC_W'($signed(prod));
      sum      = acc + prod_ext;
      ovf_add  = (acc[ACC_W-1] == prod_ext[ACC_W-1]) &
                 (sum[ACC_W-1] != acc[ACC_W-1]);
      last     = (cnt == CW'(LEN - 1));
      // Only a last term can be blocked by an undrained result.
      stall    = p_valid & last & out_valid & ~out_ready;
      in_ready = ~rst & ~stall;
      absorb   = p_valid & ~stall;
      load     = absorb & last;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         op_a      <= '0;
         op_b      <= '0;
         p_valid   <= 1'b0;
         acc       <= '0;
         grp_ovf   <= 1'b0;
         cnt       <= '0;
         out_valid <= 1'b0;
         out_acc   <= '0;
         out_ovf   <= 1'b0;
      end else begin
         if (!stall) begin
            if (in_valid) begin
               op_a    <= in_a;
               op_b    <= in_b;
               p_valid <= 1'b1;
            end else begin
               p_valid <= 1'b0;
            end
         end

         if (absorb) begin
            if (last) begin
               acc     <= '0;
               grp_ovf <= 1'b0;
               cnt     <= '0;
            end else begin
               acc     <= sum;
               grp_ovf <= grp_ovf | ovf_add;
               cnt     <= cnt + CW'(1);
            end
         end

         // A coincident load wins over a drain so out_valid stays set.
         if (load) begin
            out_acc   <= sum;
            out_ovf   <= grp_ovf | ovf_add;
            out_valid <= 1'b1;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule
